// File: rtl/fft_pkg.sv
// Shared types and constants for the decimal FFT front end.
// Sample bundle, bank states and the index bit-reversal helper.
package fft_pkg;

  localparam int N_PTS = 8;
  localparam int IDX_W = 3;

  typedef struct packed {
    logic signed [15:0] whole;
    logic [15:0]        frac;
    logic               flag;
  } dec_sample_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_e;

  function automatic logic [IDX_W-1:0] bitrev3(
    input logic [IDX_W-1:0] i
  );
    return {i[0], i[1], i[2]};
  endfunction

endpackage

// File: rtl/dec_sample_norm.sv
// Sample normaliser: clips the fraction and derives the sign flag.
// Purely combinational; sits on the loader write path.
module dec_sample_norm
  import fft_pkg::*;
#(
  parameter int FRAC_MAX = 99
) (
  input  logic signed [15:0] whole,
  input  logic [15:0]        frac,
  input  logic               flag,
  output dec_sample_t        smp,
  output logic               clip
);

  localparam logic [15:0] FMAX = FRAC_MAX[15:0];

  always_comb begin
    clip      = (frac > FMAX);
    smp.whole = whole;
    smp.frac  = clip ? FMAX : frac;
    // A zero whole part cannot carry a sign, so the marker supplies it.
    smp.flag  = (whole != 16'sd0) ? whole[15] : flag;
  end

endmodule

// File: rtl/fft_sample_loader.sv
// Ping-pong frame loader feeding decimal_fft with 8 parallel lanes.
// Define BIT_REVERSE_EN to store samples in bit-reversed lane order.
module fft_sample_loader
  import fft_pkg::*;
#(
  parameter int FRAC_MAX = 99
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [15:0]  s_whole,
  input  logic [15:0]  s_frac,
  input  logic         s_flag,
  input  logic         s_last,
  output logic [127:0] rin_whole,
  output logic [127:0] rin_frac,
  output logic [7:0]   rin_flag,
  output logic         frame_valid,
  input  logic         frame_ready,
  output logic         frame_err,
  output logic         frac_clip,
  output logic [15:0]  frame_cnt
);

  bank_state_e      bank_q [2];
  bank_state_e      bank_d [2];
  dec_sample_t      mem_q  [2][N_PTS];
  dec_sample_t      mem_d  [2][N_PTS];
  dec_sample_t      rin_q  [N_PTS];
  dec_sample_t      rin_d  [N_PTS];
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d, lane;
  logic             wbank_q, wbank_d;
  logic             rbank_q, rbank_d;
  logic             s_ready_q, s_ready_d;
  logic             fv_q, fv_d;
  logic             err_q, err_d;
  logic             clip_q, clip_d;
  logic [15:0]      cnt_q, cnt_d;

  dec_sample_t      nsmp;
  logic             nclip;
  logic             accept, handoff;
  logic             at_end, bad;

  dec_sample_norm #(
    .FRAC_MAX (FRAC_MAX)
  ) u_norm (
    .whole (s_whole),
    .frac  (s_frac),
    .flag  (s_flag),
    .smp   (nsmp),
    .clip  (nclip)
  );

`ifdef BIT_REVERSE_EN
  assign lane = bitrev3(wr_idx_q);
`else
  assign lane = wr_idx_q;
`endif

  assign accept  = s_valid & s_ready_q;
  assign handoff = fv_q & frame_ready;
  assign at_end  = (wr_idx_q == IDX_W'(N_PTS - 1));
  assign bad     = s_last ^ at_end;

  always_comb begin
    bank_d    = bank_q;
    mem_d     = mem_q;
    rin_d     = rin_q;
    wr_idx_d  = wr_idx_q;
    wbank_d   = wbank_q;
    rbank_d   = rbank_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    clip_d    = 1'b0;

    // Handoff and accept always target different banks.
    if (handoff) begin
      bank_d[rbank_q] = EMPTY;
      rbank_d         = ~rbank_q;
      cnt_d           = cnt_q + 16'd1;
    end

    if (accept) begin
      clip_d = nclip;
      if (bad) begin
        bank_d[wbank_q] = EMPTY;
        wr_idx_d        = '0;
        err_d           = 1'b1;
      end else begin
        mem_d[wbank_q][lane] = nsmp;
        if (at_end) begin
          bank_d[wbank_q] = FULL;
          wbank_d         = ~wbank_q;
          wr_idx_d        = '0;
        end else begin
          bank_d[wbank_q] = FILLING;
          wr_idx_d        = wr_idx_q + 3'd1;
        end
      end
    end

    s_ready_d = (bank_d[wbank_d] != FULL);
    fv_d      = (bank_d[rbank_d] == FULL);
    if (fv_d) begin
      for (int k = 0; k < N_PTS; k++) rin_d[k] = mem_d[rbank_d][k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        bank_q[b] <= EMPTY;
        for (int k = 0; k < N_PTS; k++) mem_q[b][k] <= '0;
      end
      for (int k = 0; k < N_PTS; k++) rin_q[k] <= '0;
      wr_idx_q  <= '0;
      wbank_q   <= 1'b0;
      rbank_q   <= 1'b0;
      s_ready_q <= 1'b0;
      fv_q      <= 1'b0;
      err_q     <= 1'b0;
      clip_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      bank_q    <= bank_d;
      mem_q     <= mem_d;
      rin_q     <= rin_d;
      wr_idx_q  <= wr_idx_d;
      wbank_q   <= wbank_d;
      rbank_q   <= rbank_d;
      s_ready_q <= s_ready_d;
      fv_q      <= fv_d;
      err_q     <= err_d;
      clip_q    <= clip_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    rin_whole = '0;
    rin_frac  = '0;
    rin_flag  = '0;
    for (int k = 0; k < N_PTS; k++) begin
      rin_whole[16*k +: 16] = rin_q[k].whole;
      rin_frac[16*k +: 16]  = rin_q[k].frac;
      rin_flag[k]           = rin_q[k].flag;
    end
  end

  assign s_ready     = s_ready_q;
  assign frame_valid = fv_q;
  assign frame_err   = err_q;
  assign frac_clip   = clip_q;
  assign frame_cnt   = cnt_q;

endmodule
